// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS-Lite pipeline: drives the pipeline
// register enables, bubbles, branch flushes and EX operand selects, and counts stalls and flushes.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 3,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic [REG_AW-1:0]     id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_AW-1:0]     ex_rs,
  input  logic [REG_AW-1:0]     ex_rt,
  input  logic [REG_AW-1:0]     ex_wn,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic                  ex_mc_start,
  input  logic [REG_AW-1:0]     mem_wn,
  input  logic                  mem_regwrite,
  input  logic [REG_AW-1:0]     wb_wn,
  input  logic                  wb_regwrite,
  input  logic                  br_taken,
  output logic                  en_pc,
  output logic                  en_ifid,
  output logic                  en_idex,
  output logic                  bubble_idex,
  output logic                  bubble_exmem,
  output logic [BR_PENALTY-1:0] flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mc_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [3:0]       MC_LOAD = 4'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic reg_match(input logic [REG_AW-1:0] d,
                                     input logic [REG_AW-1:0] s,
                                     input logic              u);
    return u && (d != '0) && (d == s);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (mem_regwrite && reg_match(mem_wn, src, 1'b1))
      return 2'b10;
    else if (wb_regwrite && reg_match(wb_wn, src, 1'b1))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != '1))
      return cnt + CNT_ONE;
    else
      return cnt;
  endfunction

  logic [3:0] mc_cnt;
  logic       mc_active;
  logic       mc_kill;
  logic       id_hits_ex;
  logic       id_hits_mem;
  logic       data_stall;

  // A branch resolved in MEM is older than the multicycle op in EX, so it kills that op.
  assign mc_kill   = br_taken && (BR_PENALTY == 3);
  assign mc_active = (mc_cnt != 4'd0) || ex_mc_start;
  assign flush     = {BR_PENALTY{br_taken}};

  always_comb begin
    id_hits_ex  = reg_match(ex_wn, id_rs, id_use_rs) || reg_match(ex_wn, id_rt, id_use_rt);
    id_hits_mem = reg_match(mem_wn, id_rs, id_use_rs) || reg_match(mem_wn, id_rt, id_use_rt);
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (FWD_EN != 0) begin
      data_stall = ex_memread && ex_regwrite && id_hits_ex;
      fwd_a      = fwd_sel(ex_rs);
      fwd_b      = fwd_sel(ex_rt);
    end else begin
      // WB matches need no interlock: the register file writes in the first half-cycle.
      data_stall = (ex_regwrite && id_hits_ex) || (mem_regwrite && id_hits_mem);
    end
  end

  always_comb begin
    en_pc        = 1'b1;
    en_ifid      = 1'b1;
    en_idex      = 1'b1;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    mc_busy      = mc_active;
    if (br_taken) begin
      mc_busy = mc_active && !mc_kill;
    end else if (mc_active) begin
      en_pc        = 1'b0;
      en_ifid      = 1'b0;
      en_idex      = 1'b0;
      bubble_exmem = 1'b1;
    end else if (data_stall) begin
      en_pc       = 1'b0;
      en_ifid     = 1'b0;
      bubble_idex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_cnt    <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mc_kill)
        mc_cnt <= 4'd0;
      else if (ex_mc_start)
        mc_cnt <= MC_LOAD;
      else if (mc_cnt != 4'd0)
        mc_cnt <= mc_cnt - 4'd1;
      stall_cnt <= sat_inc(stall_cnt, !en_pc);
      flush_cnt <= sat_inc(flush_cnt, br_taken);
    end
  end

  mc_start_while_busy: assert property (@(posedge clk) disable iff (rst)
                                        !(ex_mc_start && (mc_cnt != 4'd0)))
    else $error("ex_mc_start asserted while the multicycle unit is busy");

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding instance and an interlock-only instance
// with a narrow counter share one stimulus stream and are checked against a reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_mc_start;
  logic       mem_regwrite, wb_regwrite, br_taken;

  logic        a_en_pc, a_en_ifid, a_en_idex, a_bubble_idex, a_bubble_exmem, a_mc_busy;
  logic [2:0]  a_flush;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_en_pc, b_en_ifid, b_en_idex, b_bubble_idex, b_bubble_exmem, b_mc_busy;
  logic [2:0]  b_flush;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [2:0]  b_stall_cnt, b_flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .BR_PENALTY(3), .MC_LAT(4), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wn(ex_wn),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_wn(mem_wn), .mem_regwrite(mem_regwrite), .wb_wn(wb_wn), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .en_pc(a_en_pc), .en_ifid(a_en_ifid), .en_idex(a_en_idex),
    .bubble_idex(a_bubble_idex), .bubble_exmem(a_bubble_exmem), .flush(a_flush),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .mc_busy(a_mc_busy), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .BR_PENALTY(3), .MC_LAT(4), .CNT_W(3)) u_ilk (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wn(ex_wn),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_wn(mem_wn), .mem_regwrite(mem_regwrite), .wb_wn(wb_wn), .wb_regwrite(wb_regwrite),
    .br_taken(br_taken), .en_pc(b_en_pc), .en_ifid(b_en_ifid), .en_idex(b_en_idex),
    .bubble_idex(b_bubble_idex), .bubble_exmem(b_bubble_exmem), .flush(b_flush),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .mc_busy(b_mc_busy), .stall_cnt(b_stall_cnt),
    .flush_cnt(b_flush_cnt));

  typedef logic [12:0] comb_t;

  int n_assert = 0;
  int n_fail   = 0;

  logic [44:0] qa[$];
  logic [18:0] qb[$];
  logic [3:0]  ma_mc, mb_mc;
  logic [15:0] ma_st, ma_fl;
  logic [2:0]  mb_st, mb_fl;
  comb_t       ca = '0, cb = '0;

  function automatic logic m(input logic [4:0] d, input logic [4:0] s, input logic u);
    return u && (d != 5'd0) && (d == s);
  endfunction

  // Expected combinational outputs {en_pc,en_ifid,en_idex,bub_idex,bub_exmem,flush,fwd_a,fwd_b,busy}
  function automatic comb_t model(input bit fwd, input logic [3:0] mc);
    logic ep, ei, ex, bi, be, busy, hit_ex, hit_mem, stall;
    logic [2:0] fl;
    logic [1:0] fa, fb;
    hit_ex  = m(ex_wn, id_rs, id_use_rs) || m(ex_wn, id_rt, id_use_rt);
    hit_mem = m(mem_wn, id_rs, id_use_rs) || m(mem_wn, id_rt, id_use_rt);
    stall   = fwd ? (ex_memread && ex_regwrite && hit_ex)
                  : ((ex_regwrite && hit_ex) || (mem_regwrite && hit_mem));
    fa = 2'b00;
    fb = 2'b00;
    if (fwd) begin
      if (mem_regwrite && m(mem_wn, ex_rs, 1'b1)) fa = 2'b10;
      else if (wb_regwrite && m(wb_wn, ex_rs, 1'b1)) fa = 2'b01;
      if (mem_regwrite && m(mem_wn, ex_rt, 1'b1)) fb = 2'b10;
      else if (wb_regwrite && m(wb_wn, ex_rt, 1'b1)) fb = 2'b01;
    end
    {ep, ei, ex, bi, be} = 5'b11100;
    fl   = 3'b000;
    busy = (mc != 4'd0) || ex_mc_start;
    if (br_taken) begin
      fl   = 3'b111;
      busy = 1'b0;
    end else if (busy) begin
      {ep, ei, ex, be} = 4'b0001;
    end else if (stall) begin
      {ep, ei, bi} = 3'b001;
    end
    return {ep, ei, ex, bi, be, fl, fa, fb, busy};
  endfunction

  function automatic logic [3:0] mc_next(input logic [3:0] mc);
    if (br_taken) return 4'd0;
    if (ex_mc_start) return 4'd3;
    if (mc != 4'd0) return mc - 4'd1;
    return mc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push expectations for the inputs now driven, then pop and compare away from the edge.
  task automatic settle();
    logic [44:0] ea;
    logic [18:0] eb;
    ca = model(1'b1, ma_mc);
    cb = model(1'b0, mb_mc);
    qa.push_back({ca, ma_st, ma_fl});
    qb.push_back({cb, mb_st, mb_fl});
    @(negedge clk);
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("sb_fwd", 64'({a_en_pc, a_en_ifid, a_en_idex, a_bubble_idex, a_bubble_exmem, a_flush,
                       a_fwd_a, a_fwd_b, a_mc_busy, a_stall_cnt, a_flush_cnt}), 64'(ea));
    chk("sb_ilk", 64'({b_en_pc, b_en_ifid, b_en_idex, b_bubble_idex, b_bubble_exmem, b_flush,
                       b_fwd_a, b_fwd_b, b_mc_busy, b_stall_cnt, b_flush_cnt}), 64'(eb));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      ma_mc = 4'd0; mb_mc = 4'd0;
      ma_st = '0; ma_fl = '0; mb_st = '0; mb_fl = '0;
    end else begin
      ma_mc = mc_next(ma_mc);
      mb_mc = mc_next(mb_mc);
      if (!ca[12] && ma_st != 16'hFFFF) ma_st = ma_st + 16'd1;
      if (br_taken && ma_fl != 16'hFFFF) ma_fl = ma_fl + 16'd1;
      if (!cb[12] && mb_st != 3'd7) mb_st = mb_st + 3'd1;
      if (br_taken && mb_fl != 3'd7) mb_fl = mb_fl + 3'd1;
    end
    #1;
  endtask

  task automatic idle();
    {id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn} = '0;
    {id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_mc_start} = '0;
    {mem_regwrite, wb_regwrite, br_taken} = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;

    // Reset state
    settle();
    chk("rst_en", 64'({a_en_pc, a_en_ifid, a_en_idex}), 64'(3'b111));
    chk("rst_bubble", 64'({a_bubble_idex, a_bubble_exmem}), 64'(0));
    chk("rst_flush", 64'(a_flush), 64'(0));
    chk("rst_fwd", 64'({a_fwd_a, a_fwd_b}), 64'(0));
    chk("rst_busy", 64'(a_mc_busy), 64'(0));
    chk("rst_cnt", 64'({a_stall_cnt, a_flush_cnt}), 64'(0));
    advance();

    // Forwarding
    {ex_rs, ex_rt, mem_wn, wb_wn} = {5'd5, 5'd5, 5'd5, 5'd5};
    {mem_regwrite, wb_regwrite} = 2'b11;
    settle();
    chk("fwd_mem_a", 64'(a_fwd_a), 64'(2'b10));
    chk("fwd_mem_b", 64'(a_fwd_b), 64'(2'b10));
    chk("ilk_no_fwd", 64'({b_fwd_a, b_fwd_b}), 64'(0));
    advance();
    mem_regwrite = 1'b0;
    settle();
    chk("fwd_wb_a", 64'(a_fwd_a), 64'(2'b01));
    advance();
    ex_rs = 5'd0;
    settle();
    chk("fwd_r0_a", 64'(a_fwd_a), 64'(2'b00));
    chk("fwd_wb_b", 64'(a_fwd_b), 64'(2'b01));
    advance();
    {mem_wn, ex_rt, mem_regwrite} = {5'd0, 5'd0, 1'b1};
    settle();
    chk("fwd_r0_b", 64'(a_fwd_b), 64'(2'b00));
    advance();

    // Load-use stall
    idle();
    {ex_memread, ex_regwrite, ex_wn, id_rt, id_use_rt} = {1'b1, 1'b1, 5'd8, 5'd8, 1'b1};
    settle();
    chk("lu_en_pc", 64'(a_en_pc), 64'(0));
    chk("lu_bubble", 64'({a_bubble_idex, a_en_idex}), 64'(2'b11));
    advance();
    {ex_memread, ex_regwrite, ex_wn} = '0;
    settle();
    chk("lu_release", 64'(a_en_pc), 64'(1));
    chk("lu_stall_cnt", 64'(a_stall_cnt), 64'(1));
    advance();

    // Interlock-only mode
    idle();
    {mem_wn, id_rs, id_use_rs, mem_regwrite} = {5'd3, 5'd3, 1'b1, 1'b1};
    settle();
    chk("ilk_mem_stall", 64'({b_en_pc, b_bubble_idex}), 64'(2'b01));
    chk("fwd_mem_nostall", 64'(a_en_pc), 64'(1));
    advance();
    {mem_wn, mem_regwrite, wb_wn, wb_regwrite} = {5'd0, 1'b0, 5'd3, 1'b1};
    settle();
    chk("ilk_wb_nostall", 64'(b_en_pc), 64'(1));
    advance();
    {wb_regwrite, ex_wn, ex_regwrite} = {1'b0, 5'd3, 1'b1};
    settle();
    chk("ilk_ex_stall", 64'(b_en_pc), 64'(0));
    chk("fwd_alu_nostall", 64'(a_en_pc), 64'(1));
    advance();

    // Multicycle op holds the front end for MC_LAT cycles
    idle();
    ex_mc_start = 1'b1;
    settle();
    chk("mc_busy_0", 64'({a_mc_busy, a_bubble_exmem, a_en_idex}), 64'(3'b110));
    advance();
    ex_mc_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("mc_busy_n", 64'({a_mc_busy, a_bubble_exmem, a_en_pc}), 64'(3'b110));
      advance();
    end
    settle();
    chk("mc_done", 64'({a_mc_busy, a_en_pc}), 64'(2'b01));
    chk("mc_stall_cnt", 64'(a_stall_cnt), 64'(5));
    advance();

    // Branch flush beats multicycle and load-use stalls
    ex_mc_start = 1'b1;
    settle();
    advance();
    ex_mc_start = 1'b0;
    br_taken = 1'b1;
    {ex_memread, ex_regwrite, ex_wn, id_rs, id_use_rs} = {1'b1, 1'b1, 5'd9, 5'd9, 1'b1};
    settle();
    chk("br_flush", 64'(a_flush), 64'(3'b111));
    chk("br_en", 64'({a_en_pc, a_en_ifid, a_en_idex, a_bubble_idex}), 64'(4'b1110));
    advance();
    idle();
    settle();
    chk("br_mc_killed", 64'(a_mc_busy), 64'(0));
    chk("br_flush_cnt", 64'(a_flush_cnt), 64'(1));
    chk("br_stall_cnt", 64'(a_stall_cnt), 64'(6));
    advance();

    // Reset mid-operation
    ex_mc_start = 1'b1;
    settle();
    advance();
    ex_mc_start = 1'b0;
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    settle();
    chk("rst_mid_busy", 64'(a_mc_busy), 64'(0));
    chk("rst_mid_cnt", 64'({a_stall_cnt, a_flush_cnt}), 64'(0));
    advance();

    // Flush counter saturation on the 3-bit instance
    br_taken = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      advance();
    end
    br_taken = 1'b0;
    settle();
    chk("sat_flush_cnt", 64'(b_flush_cnt), 64'(3'b111));
    chk("nosat_flush_cnt", 64'(a_flush_cnt), 64'(8));
    advance();
    br_taken = 1'b1;
    settle();
    advance();
    br_taken = 1'b0;
    settle();
    chk("sat_hold", 64'(b_flush_cnt), 64'(3'b111));
    chk("nosat_inc", 64'(a_flush_cnt), 64'(9));
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS-Lite pipeline, replacing the fixed "always-enabled PC, no forwarding" scheme. It supports:

- Forwarding or interlock-only operation.
- Load-use stalls.
- Branch/jump flush with configurable resolve stage.
- Stalls for a multicycle EX unit (mult/div) of configurable latency.
- Saturating stall/flush performance counters.

It sits beside the pipeline registers and drives their enables, bubbles, flushes and the EX operand-select muxes.

## Interface
Parameters:
- REG_AW, 5, register-number width.
- FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = interlock-only.
- BR_PENALTY, 3, stages flushed on a taken branch (1 = resolved in ID, 2 = EX, 3 = MEM); legal 1..3.
- MC_LAT, 4, cycles a multicycle op occupies EX; legal 2..16.
- CNT_W, 16, performance-counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  source actually read.
- ex_rs, ex_rt  in  REG_AW  source registers of the instruction in EX.
- ex_wn  in  REG_AW  destination of the instruction in EX.
- ex_regwrite, ex_memread  in  1  EX control bits.
- ex_mc_start  in  1  a multicycle op enters EX this cycle.
- mem_wn  in  REG_AW  destination in MEM; mem_regwrite  in  1.
- wb_wn  in  REG_AW  destination in WB; wb_regwrite  in  1.
- br_taken  in  1  branch/jump resolved taken in stage BR_PENALTY.
- en_pc, en_ifid, en_idex  out  1  load enables.
- bubble_idex, bubble_exmem  out  1  zero control fields entering that register.
- flush  out  BR_PENALTY  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data.
- mc_busy  out  1  multicycle unit occupying EX.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- **Register 0:** never a hazard source. Any match against register 0 is ignored.
- **Match term:** match(d, s, u) = u && d != 0 && d == s.
- **Forwarding (FWD_EN=1):**
  - fwd_a = 10 if mem_regwrite && mem_wn match ex_rs.
  - Otherwise fwd_a = 01 if wb_regwrite && wb_wn match ex_rs.
  - Otherwise fwd_a = 00.
  - fwd_b is the same with ex_rt.
  - The MEM match wins over the WB match.
- **Forwarding (FWD_EN=0):** fwd_a = fwd_b = 00 always.
- **Load-use stall (FWD_EN=1):** asserted when ex_memread && ex_regwrite && (match(ex_wn, id_rs, id_use_rs) || match(ex_wn, id_rt, id_use_rt)).
- **RAW stall (FWD_EN=0):** asserted when an ID source matches ex_wn with ex_regwrite, or mem_wn with mem_regwrite. No stall on a WB match: the register file writes in the first half-cycle.
- **Data-stall effect:** en_pc = en_ifid = 0, bubble_idex = 1, en_idex = 1.
- **Multicycle counter mc_cnt (4 bits, internal):**
  - ex_mc_start loads MC_LAT-1.
  - While mc_cnt != 0 it decrements each cycle.
  - mc_busy = (mc_cnt != 0) || ex_mc_start.
- **Multicycle-stall effect:** while mc_busy, en_pc = en_ifid = en_idex = 0 and bubble_exmem = 1. The final cycle, with mc_cnt = 1, is also held.
- **Branch flush:** br_taken drives flush to all ones, combinationally. en_pc = 1 so the target loads.
- **Priority:** branch flush > multicycle stall > data stall.
  - On a flush, any data stall in the same cycle is suppressed.
  - If BR_PENALTY = 3 and br_taken coincides with mc_busy, the EX op is younger and is killed: mc_cnt is cleared to 0 at the edge and mc_busy, en_pc and the enables follow flush rules that cycle.
  - If BR_PENALTY < 3, a br_taken cannot coincide with mc_busy (the branch is stalled in ID/EX). Behaviour in that case is unspecified.
- **Counters:**
  - stall_cnt increments on every cycle with en_pc = 0.
  - flush_cnt increments on every cycle with br_taken.
  - Both saturate at all-ones and never wrap.

## Timing
- All outputs except stall_cnt and flush_cnt are combinational from the inputs and mc_cnt. There is no added latency, so decisions apply at the next edge.
- stall_cnt, flush_cnt and mc_cnt update on the rising edge of clk.
- Reset values: mc_cnt = 0, stall_cnt = 0, flush_cnt = 0.
- With all inputs at 0 after reset: en_pc = en_ifid = en_idex = 1, bubble_* = 0, flush = 0, fwd_* = 00, mc_busy = 0.
- rst asserted mid-operation clears mc_cnt and the counters at that edge. It takes priority over ex_mc_start and br_taken.
- Load-use stall lasts exactly 1 cycle, because the bubble removes the load from EX.
- An isolated multicycle op holds the front end for exactly MC_LAT cycles.
- ex_mc_start while mc_busy is illegal; the RTL asserts a simulation error.

## Test plan
- **Reset:** rst = 1 for 2 cycles, then idle → enables = 1, flush = 0, fwd = 00, counters = 0.
- **Forwarding:** FWD_EN=1, mem_wn = wb_wn = ex_rs = 5, both regwrite = 1 → fwd_a = 10. Drop mem_regwrite → 01. Set ex_rs = 0 → 00.
- **Load-use:** ex_memread = ex_regwrite = 1, ex_wn = 8, id_rt = 8, id_use_rt = 1 → one cycle en_pc = 0, bubble_idex = 1; stall_cnt = 1.
- **Interlock mode:** FWD_EN=0, mem_wn = id_rs = 3, mem_regwrite = 1 → stall. Same match on WB only → no stall.
- **Multicycle:** MC_LAT=4, ex_mc_start pulse → mc_busy high for exactly 4 cycles, bubble_exmem = 1 throughout, stall_cnt = 4.
- **Flush priority:**
  - BR_PENALTY=3: br_taken on the 2nd mc_busy cycle together with a load-use match → flush = 111, en_pc = 1, mc_cnt = 0 next cycle, flush_cnt = 1.
  - Force flush_cnt to 2^CNT_W−1 (e.g. 65535 for CNT_W=16) via repeated br_taken or a CNT_W=2 build, then pulse br_taken → the counter stays at all-ones.
